mov_obj_tracker: RTL and testbench
==================================

// Module: mov_obj_tracker
// PURPOSE
//  Parametrised multi-object bounding-box tracker for the 1-bit frame-difference motion stream from the ISP.
//  - Clusters motion pixels into up to N_OBJ boxes per frame and publishes them at frame end.
//  - Drops boxes smaller than MIN_SIZE and flags slot overflow.
//  - Provides a raw object count and a temporally filtered count.
//  Sits between the ISP binarisation stage and the boundary-fusion / seg-display stages, in the cam_pclk domain.
// PARAMETERS
//  H_PIXEL        800  active pixels per line
//  V_PIXEL        600  active lines per frame
//  N_OBJ          16   box slots, 1..32
//  MIN_DISC       100  merge distance in pixels; a pixel joins a box when within MIN_DISC of it on both axes
//  MIN_SIZE       4    a box is published only if its width and its height are both >= MIN_SIZE
//  STABLE_FRAMES  3    consecutive equal counts required before obj_num_stable updates, >= 1
//  Derived: X_W = $clog2(H_PIXEL), Y_W = $clog2(V_PIXEL), BOX_W = 1 + 2*X_W + 2*Y_W
// PORTS
//  sys_clk         in   1            pixel clock (cam_pclk); the only clock
//  sys_rst_n       in   1            asynchronous, active-low reset
//  pre_vs          in   1            frame valid, active high
//  pre_hs          in   1            line valid, active high
//  pre_wr_en       in   1            pixel strobe
//  pre_1bit        in   1            motion bit, 1 = moving
//  frame_done      out  1            one-cycle pulse when box_data and the counts update
//  box_data        out  N_OBJ*BOX_W  slot i occupies [i*BOX_W +: BOX_W] as {valid, xmin, xmax, ymin, ymax}
//  obj_num         out  8            published box count of the last frame
//  obj_num_stable  out  8            temporally filtered count
//  overflow        out  1            last frame had a pixel that needed a slot when none was free
// BEHAVIOUR
//  Reset: every output is 0; working slots are cleared; x, y, the run counter and the last count are 0.
//  Position counters:
//  - pix = pre_vs & pre_hs & pre_wr_en.
//  - x increments on each pix and saturates at H_PIXEL-1. x returns to 0 on a pre_hs falling edge.
//  - y increments on a pre_hs falling edge and saturates at V_PIXEL-1. y returns to 0 at frame start.
//  - Edges are detected against the 1-cycle registered copies vs_d1 and hs_d1.
//  Frame start (pre_vs=1, vs_d1=0):
//  - All working slots are cleared and the overflow accumulator is cleared.
//  - A pixel in the same cycle is processed after the clear, so it lands in slot 0.
//  Pixel update (pix & pre_1bit), 1-cycle latency into the working slots:
//  - near(i) = valid_i & x+MIN_DISC >= xmin_i & x <= xmax_i+MIN_DISC, with the same test on y.
//  - All compares are done at X_W+1 / Y_W+1 bits, so there is no underflow.
//  - If any slot is near, only the lowest-index near slot updates: xmin = min, xmax = max, ymin = min, ymax = max.
//  - If no slot is near, the lowest free slot is loaded with {1, x, x, y, y}.
//  - If no slot is near and none is free, the pixel is dropped and the overflow accumulator is set.
//  - Existing boxes are never merged with each other.
//  Frame end (pre_vs=0, vs_d1=1), registered in cycle t; all effects below are visible at t+1:
//  - box_data[i] = the working slot with valid = valid_i & (xmax-xmin+1 >= MIN_SIZE) & (ymax-ymin+1 >= MIN_SIZE).
//  - Slots are not compacted.
//  - obj_num = popcount of the published valid bits.
//  - overflow = the overflow accumulator.
//  - frame_done = 1 for exactly one cycle.
//  - Stability filter: if the new count equals the last count, run increments, saturating at STABLE_FRAMES; otherwise run = 1.
//  - The last count is then updated to the new count.
//  - When run reaches STABLE_FRAMES, obj_num_stable = the new count.
//  - With STABLE_FRAMES=1, obj_num_stable always tracks obj_num.
//  Outputs hold their values between frame ends. A reset in mid-frame aborts the frame; the next complete frame publishes normally.
//  A vs falling edge with no pixels publishes all-invalid slots and obj_num=0.
// STRUCTURE
//  Package mov_obj_pkg holds:
//  - box_t, the packed struct {valid, xmin, xmax, ymin, ymax}
//  - the X_W/Y_W helper function
//  - function box_near(box_t, x, y, disc)
//  - function box_grow(box_t, x, y)
//  Sub-module mov_obj_slot holds one working box register and its near/free flags. It is generated N_OBJ times.
//  The top level holds the counters, the priority near/free encoders, the publish registers, the popcount and the stability FSM.
// TESTING
//  Test configuration: 800x600 frames, defaults unless stated.
//  1. 10x10 blob at x 100..109, y 50..59 -> frame_done pulse; slot0 = {1,100,109,50,59}; obj_num=1; others invalid.
//  2. Blobs at x 100..109 and x 400..409 (same rows) -> 2 valid slots, obj_num=2; move the second blob to x 150..159 -> 1 slot {1,100,159,..}, obj_num=1.
//  3. 2x2 blob alone -> working slot is used, published valid=0, obj_num=0, overflow=0.
//  4. N_OBJ=4 with 5 blobs spaced 150 px apart -> slots 0..3 valid, obj_num=4, overflow=1; the next clean frame gives overflow=0.
//  5. Frame counts 1,1,1,2,2,2 -> obj_num_stable 0,0,1,1,1,2 after each frame_done.
//  6. Assert sys_rst_n low mid-frame -> all outputs 0 immediately; the next full frame with scenario-1 stimulus gives the scenario-1 result.

Source files
------------

// File: rtl/mov_obj_pkg.sv
// mov_obj_pkg: box record, coordinate widths and box helpers
// shared by the motion-object tracker and its slot registers.
package mov_obj_pkg;

   localparam int H_PIXEL_DEF = 800;
   localparam int V_PIXEL_DEF = 600;

   function automatic int coord_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int X_W   = coord_w(H_PIXEL_DEF);
   localparam int Y_W   = coord_w(V_PIXEL_DEF);
   localparam int BOX_W = 1 + 2*X_W + 2*Y_W;

   typedef struct packed {
      logic           valid;
      logic [X_W-1:0] xmin;
      logic [X_W-1:0] xmax;
      logic [Y_W-1:0] ymin;
      logic [Y_W-1:0] ymax;
   } box_t;

   // One extra bit on every compare keeps x+disc from wrapping
   function automatic logic box_near(
      input box_t           b,
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y,
      input int             disc
   );
      logic [X_W:0] xd;
      logic [Y_W:0] yd;
      xd = (X_W+1)'(disc);
      yd = (Y_W+1)'(disc);
      return b.valid
         & ({1'b0, x} + xd >= {1'b0, b.xmin})
         & ({1'b0, x} <= {1'b0, b.xmax} + xd)
         & ({1'b0, y} + yd >= {1'b0, b.ymin})
         & ({1'b0, y} <= {1'b0, b.ymax} + yd);
   endfunction

   function automatic box_t box_grow(
      input box_t           b,
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y
   );
      box_t r;
      r       = b;
      r.xmin  = (x < b.xmin) ? x : b.xmin;
      r.xmax  = (x > b.xmax) ? x : b.xmax;
      r.ymin  = (y < b.ymin) ? y : b.ymin;
      r.ymax  = (y > b.ymax) ? y : b.ymax;
      return r;
   endfunction

   function automatic logic box_big(input box_t b, input int min_size);
      logic [X_W:0] w;
      logic [Y_W:0] h;
      w = {1'b0, b.xmax} - {1'b0, b.xmin} + (X_W+1)'(1);
      h = {1'b0, b.ymax} - {1'b0, b.ymin} + (Y_W+1)'(1);
      return (w >= (X_W+1)'(min_size)) & (h >= (Y_W+1)'(min_size));
   endfunction

endpackage

// File: rtl/mov_obj_slot.sv
// mov_obj_slot: one working bounding-box register with its
// near / free flags for the tracker's priority encoders.
module mov_obj_slot
   import mov_obj_pkg::*;
#(
   parameter int MIN_DISC = 100
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           load,
   input  logic           grow,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   output box_t           box,
   output logic           near,
   output logic           free
);

   // A clear in this cycle makes the slot look empty to the same-cycle pixel
   assign near = ~clr & box_near(box, x, y, MIN_DISC);
   assign free = clr | ~box.valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box <= '0;
      end else if (load) begin
         box <= '{valid: 1'b1, xmin: x, xmax: x, ymin: y, ymax: y};
      end else if (grow) begin
         box <= box_grow(box, x, y);
      end else if (clr) begin
         box <= '0;
      end
   end

endmodule

// File: rtl/mov_obj_tracker.sv
// mov_obj_tracker: clusters 1-bit motion pixels into bounding boxes and
// publishes them with a raw and a temporally filtered count at frame end.
module mov_obj_tracker
   import mov_obj_pkg::*;
#(
   parameter int H_PIXEL       = 800,
   parameter int V_PIXEL       = 600,
   parameter int N_OBJ         = 16,
   parameter int MIN_DISC      = 100,
   parameter int MIN_SIZE      = 4,
   parameter int STABLE_FRAMES = 3
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   pre_vs,
   input  logic                   pre_hs,
   input  logic                   pre_wr_en,
   input  logic                   pre_1bit,
   output logic                   frame_done,
   output logic [N_OBJ*BOX_W-1:0] box_data,
   output logic [7:0]             obj_num,
   output logic [7:0]             obj_num_stable,
   output logic                   overflow
);

   logic           vs_d1, hs_d1;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y, y_eff;
   logic           pix, upd, frame_start, frame_end, hs_fall;

   box_t             slot_box [N_OBJ];
   logic [N_OBJ-1:0] near_v, free_v, load_v, grow_v, pub_v;
   logic             near_found, free_found, ovf_set, ovf_acc;

   logic [N_OBJ*BOX_W-1:0] pub_data;
   logic [7:0]             new_cnt, last_cnt, run, run_nxt;

   assign pix         = pre_vs & pre_hs & pre_wr_en;
   assign upd         = pix & pre_1bit;
   assign frame_start = pre_vs & ~vs_d1;
   assign frame_end   = ~pre_vs & vs_d1;
   assign hs_fall     = ~pre_hs & hs_d1;
   assign y_eff       = frame_start ? '0 : y;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vs_d1 <= 1'b0;
         hs_d1 <= 1'b0;
         x     <= '0;
         y     <= '0;
      end else begin
         vs_d1 <= pre_vs;
         hs_d1 <= pre_hs;
         if (hs_fall)
            x <= '0;
         else if (pix && x != X_W'(H_PIXEL-1))
            x <= x + X_W'(1);
         if (frame_start)
            y <= '0;
         else if (hs_fall && y != Y_W'(V_PIXEL-1))
            y <= y + Y_W'(1);
      end
   end

   for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
      mov_obj_slot #(.MIN_DISC(MIN_DISC)) u_slot (
         .clk   (sys_clk),
         .rst_n (sys_rst_n),
         .clr   (frame_start),
         .load  (load_v[i]),
         .grow  (grow_v[i]),
         .x     (x),
         .y     (y_eff),
         .box   (slot_box[i]),
         .near  (near_v[i]),
         .free  (free_v[i])
      );
   end

   // Lowest-index near slot grows; otherwise lowest free slot is loaded
   always_comb begin
      grow_v     = '0;
      load_v     = '0;
      near_found = 1'b0;
      free_found = 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
         if (near_v[i] && !near_found) begin
            grow_v[i]  = upd;
            near_found = 1'b1;
         end
         if (!(|near_v) && free_v[i] && !free_found) begin
            load_v[i]  = upd;
            free_found = 1'b1;
         end
      end
      ovf_set = upd & ~(|near_v) & ~(|free_v);
   end

   always_comb begin
      pub_v    = '0;
      pub_data = '0;
      new_cnt  = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         pub_v[i] = slot_box[i].valid & box_big(slot_box[i], MIN_SIZE);
         pub_data[i*BOX_W +: BOX_W] = {pub_v[i], slot_box[i].xmin,
            slot_box[i].xmax, slot_box[i].ymin, slot_box[i].ymax};
         new_cnt = new_cnt + 8'(pub_v[i]);
      end
   end

   assign run_nxt = (new_cnt != last_cnt) ? 8'd1 :
                    (run >= 8'(STABLE_FRAMES)) ? run : run + 8'd1;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_done     <= 1'b0;
         box_data       <= '0;
         obj_num        <= '0;
         obj_num_stable <= '0;
         overflow       <= 1'b0;
         ovf_acc        <= 1'b0;
         last_cnt       <= '0;
         run            <= '0;
      end else begin
         frame_done <= frame_end;
         if (frame_start)
            ovf_acc <= 1'b0;
         else if (ovf_set)
            ovf_acc <= 1'b1;
         if (frame_end) begin
            box_data <= pub_data;
            obj_num  <= new_cnt;
            overflow <= ovf_acc;
            run      <= run_nxt;
            last_cnt <= new_cnt;
            if (run_nxt == 8'(STABLE_FRAMES))
               obj_num_stable <= new_cnt;
         end
      end
   end

endmodule

// File: tb/tb_mov_obj_tracker.sv
// tb_mov_obj_tracker: directed frames with hand-computed boxes and counts,
// scoreboard queue filled by the stimulus and drained by a monitor.
module tb_mov_obj_tracker;
   import mov_obj_pkg::*;

   localparam int N  = 16;
   localparam int N4 = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic vs = 1'b0, hs = 1'b0, we = 1'b0, bit1 = 1'b0;

   logic               fd, fd4, ovf, ovf4;
   logic [N*BOX_W-1:0]  bd;
   logic [N4*BOX_W-1:0] bd4;
   logic [7:0]          num, stab, num4, stab4;

   always #5 clk = ~clk;

   mov_obj_tracker dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .pre_vs(vs), .pre_hs(hs),
      .pre_wr_en(we), .pre_1bit(bit1), .frame_done(fd), .box_data(bd),
      .obj_num(num), .obj_num_stable(stab), .overflow(ovf)
   );

   mov_obj_tracker #(.N_OBJ(N4)) dut4 (
      .sys_clk(clk), .sys_rst_n(rst_n), .pre_vs(vs), .pre_hs(hs),
      .pre_wr_en(we), .pre_1bit(bit1), .frame_done(fd4), .box_data(bd4),
      .obj_num(num4), .obj_num_stable(stab4), .overflow(ovf4)
   );

   typedef struct {
      int x0, y0, w, h;
   } rect_t;

   typedef struct {
      logic [N*BOX_W-1:0]  bd;
      logic [N4*BOX_W-1:0] bd4;
      int                  num, stab, num4;
      bit                  ovf, ovf4;
   } exp_t;

   rect_t rects[$];
   exp_t  sb[$];
   exp_t  me;
   int    vectors = 0;
   int    errs = 0;
   bit    pend = 1'b0;

   task automatic chk(input string nm, input logic [1023:0] act,
                      input logic [1023:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [BOX_W-1:0] bx(input bit v, input int x0,
      input int x1, input int y0, input int y1);
      return {v, X_W'(x0), X_W'(x1), Y_W'(y0), Y_W'(y1)};
   endfunction

   function automatic exp_t mk(input int num, input int stab);
      exp_t e;
      e.bd   = '0;
      e.bd4  = '0;
      e.num  = num;
      e.num4 = num;
      e.stab = stab;
      e.ovf  = 1'b0;
      e.ovf4 = 1'b0;
      return e;
   endfunction

   function automatic exp_t put(input exp_t ei, input int i,
                                input logic [BOX_W-1:0] b);
      exp_t e;
      e = ei;
      e.bd[i*BOX_W +: BOX_W] = b;
      if (i < N4) e.bd4[i*BOX_W +: BOX_W] = b;
      return e;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit inside_any(input int px, input int py);
      foreach (rects[k])
         if (px >= rects[k].x0 && px < rects[k].x0 + rects[k].w &&
             py >= rects[k].y0 && py < rects[k].y0 + rects[k].h)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic send_frame(input int abort_line);
      int ymax, len;
      ymax = 0;
      foreach (rects[k])
         if (rects[k].y0 + rects[k].h > ymax) ymax = rects[k].y0 + rects[k].h;
      vs = 1'b1;
      cyc(2);
      for (int ly = 0; ly < ymax; ly++) begin
         if (ly == abort_line) begin
            rst_n = 1'b0;
            vs = 1'b0; hs = 1'b0; we = 1'b0; bit1 = 1'b0;
            return;
         end
         len = 0;
         foreach (rects[k])
            if (ly >= rects[k].y0 && ly < rects[k].y0 + rects[k].h &&
                rects[k].x0 + rects[k].w > len)
               len = rects[k].x0 + rects[k].w;
         hs = 1'b1;
         if (len == 0) cyc(1);
         for (int lx = 0; lx < len; lx++) begin
            we = 1'b1;
            bit1 = inside_any(lx, ly);
            cyc(1);
         end
         hs = 1'b0; we = 1'b0; bit1 = 1'b0;
         cyc(2);
      end
      vs = 1'b0;
      cyc(4);
   endtask

   task automatic add(input int x0, input int y0, input int w, input int h);
      rect_t r;
      r.x0 = x0; r.y0 = y0; r.w = w; r.h = h;
      rects.push_back(r);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bd"}, bd, 0);
      chk({tag, "_bd4"}, bd4, 0);
      chk({tag, "_num"}, {num, stab, num4, stab4}, 0);
      chk({tag, "_flags"}, {fd, fd4, ovf, ovf4}, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (pend) begin
            chk("frame_done_width", {fd, fd4}, 0);
            pend = 1'b0;
         end
         if (fd) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame_done", 1, 0);
            end else begin
               me = sb.pop_front();
               chk("frame_done4", fd4, 1);
               chk("box_data", bd, me.bd);
               chk("box_data4", bd4, me.bd4);
               chk("obj_num", num, me.num);
               chk("obj_num4", num4, me.num4);
               chk("obj_num_stable", stab, me.stab);
               chk("obj_num_stable4", stab4, me.stab);
               chk("overflow", ovf, me.ovf);
               chk("overflow4", ovf4, me.ovf4);
               pend = 1'b1;
            end
         end
      end
   end

   exp_t e;

   initial begin
      #1 rst_n = 1'b0;
      cyc(3);
      chk_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // single 10x10 blob
      rects.delete(); add(100, 50, 10, 10);
      e = put(mk(1, 0), 0, bx(1, 100, 109, 50, 59));
      sb.push_back(e); send_frame(-1);

      // two separate blobs
      rects.delete(); add(100, 50, 10, 10); add(400, 50, 10, 10);
      e = put(mk(2, 0), 0, bx(1, 100, 109, 50, 59));
      e = put(e, 1, bx(1, 400, 409, 50, 59));
      sb.push_back(e); send_frame(-1);

      // second blob within merge distance joins slot 0
      rects.delete(); add(100, 50, 10, 10); add(150, 50, 10, 10);
      e = put(mk(1, 0), 0, bx(1, 100, 159, 50, 59));
      sb.push_back(e); send_frame(-1);

      // 2x2 blob is tracked but not published
      rects.delete(); add(300, 20, 2, 2);
      e = put(mk(0, 0), 0, bx(0, 300, 301, 20, 21));
      sb.push_back(e); send_frame(-1);

      // five blobs: the 4-slot tracker overflows
      rects.delete();
      for (int i = 0; i < 5; i++) add(150*i, 10, 4, 4);
      e = mk(5, 0);
      for (int i = 0; i < 5; i++) e = put(e, i, bx(1, 150*i, 150*i+3, 10, 13));
      e.num4 = 4; e.ovf4 = 1'b1;
      sb.push_back(e); send_frame(-1);

      // counts 1,1,1,2,2,2 drive the stability filter
      for (int f = 0; f < 6; f++) begin
         rects.delete(); add(100, 20, 4, 4);
         if (f >= 3) add(300, 20, 4, 4);
         e = put(mk(f < 3 ? 1 : 2, f < 2 ? 0 : (f < 5 ? 1 : 2)), 0,
                 bx(1, 100, 103, 20, 23));
         if (f >= 3) e = put(e, 1, bx(1, 300, 303, 20, 23));
         sb.push_back(e); send_frame(-1);
      end

      // frame without pixels
      rects.delete();
      sb.push_back(mk(0, 2)); send_frame(-1);

      // reset in the middle of a frame
      rects.delete(); add(100, 50, 10, 10);
      send_frame(55);
      #1;
      chk_zero("midframe_reset");
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      e = put(mk(1, 0), 0, bx(1, 100, 109, 50, 59));
      sb.push_back(e); send_frame(-1);

      for (int i = 0; i < 100 && sb.size() != 0; i++) cyc(1);
      chk("scoreboard_drain", sb.size(), 0);
      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
